// File: rtl/seq_rem_if.sv
// Handshake bundle for seq_rem: operand request channel and remainder response channel.
interface seq_rem_if #(parameter int W = 2) ();
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   numerator;
  logic [W:0]   denominator;
  logic         mode;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   remainder;
  logic         zero;
  logic         divbyzero;

  modport master (
    output in_valid, numerator, denominator, mode, out_ready,
    input  in_ready, out_valid, remainder, zero, divbyzero
  );

  modport slave (
    input  in_valid, numerator, denominator, mode, out_ready,
    output in_ready, out_valid, remainder, zero, divbyzero
  );
endinterface

// File: rtl/seq_rem.sv
// Sequential sign-magnitude remainder: one restoring shift-subtract step per cycle,
// truncated (mode 0) or floored (mode 1) sign convention, divide-by-zero bypass.
module seq_rem #(
  parameter int W = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  seq_rem_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [W:0]    r_prem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_dmag;
  logic          r_nsgn, r_dsgn, r_mode;
  logic [W:0]    r_rem;
  logic          r_zero, r_dbz;

  logic          w_acc, w_in_dz, w_ge, w_fsgn;
  logic [W:0]    w_shift, w_prem_nx, w_fmag;

  assign w_acc   = bus.in_valid && (r_state == IDLE);
  assign w_in_dz = (bus.denominator[W-1:0] == '0);

  // Partial remainder stays below |den|, so W+1 bits hold the shifted value without overflow.
  assign w_shift   = (r_prem << 1) | {{W{1'b0}}, r_quo[W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dmag});
  assign w_prem_nx = w_ge ? (w_shift - {1'b0, r_dmag}) : w_shift;

  // Floored fix-up only when a nonzero remainder has signs that disagree.
  assign w_fmag = (r_mode && (w_prem_nx != '0) && (r_nsgn != r_dsgn))
                  ? ({1'b0, r_dmag} - w_prem_nx) : w_prem_nx;
  assign w_fsgn = (w_fmag == '0) ? 1'b0 : (r_mode ? r_dsgn : r_nsgn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = w_in_dz ? DONE : CALC;
      CALC:    if (r_cnt == '0)  w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_prem <= '0;
      r_quo  <= '0;
      r_dmag <= '0;
      r_nsgn <= 1'b0;
      r_dsgn <= 1'b0;
      r_mode <= 1'b0;
      r_rem  <= '0;
      r_zero <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (w_acc) begin
      r_cnt  <= CW'(W - 1);
      r_prem <= '0;
      r_quo  <= bus.numerator[W-1:0];
      r_dmag <= bus.denominator[W-1:0];
      r_nsgn <= bus.numerator[W];
      r_dsgn <= bus.denominator[W];
      r_mode <= bus.mode;
      if (w_in_dz) begin
        r_rem  <= bus.numerator;
        r_zero <= (bus.numerator[W-1:0] == '0);
        r_dbz  <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_prem <= w_prem_nx;
      r_quo  <= r_quo << 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_rem  <= {w_fsgn, w_fmag[W-1:0]};
        r_zero <= (w_fmag == '0);
        r_dbz  <= 1'b0;
      end
    end
  end

  assign bus.remainder = r_rem;
  assign bus.zero      = r_zero;
  assign bus.divbyzero = r_dbz;
endmodule

// File: tb/tb_seq_rem.sv
// Directed + exhaustive bench for seq_rem (W=4 and W=2 instances) with an expectation queue.
module tb_seq_rem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_rem_if #(.W(4)) b4 ();
  seq_rem_if #(.W(2)) b2 ();

  seq_rem #(.W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
  seq_rem #(.W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  typedef struct packed {
    logic [31:0] rem;
    logic        z;
    logic        dz;
    logic [7:0]  lat;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int nchk = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    assert (act === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Independent model: magnitudes via %, then sign convention and -0 suppression.
  function automatic void ref_m(input int w, input int num, input int den, input bit md,
                                output int rem, output bit z, output bit dz);
    int nm, ns, dm, ds, r, m, s;
    nm = num & ((1 << w) - 1); ns = (num >> w) & 1;
    dm = den & ((1 << w) - 1); ds = (den >> w) & 1;
    if (dm == 0) begin
      rem = num; z = (nm == 0); dz = 1'b1;
    end else begin
      r = nm % dm;
      if (!md) begin s = ns; m = r; end
      else begin s = ds; m = (r != 0 && ns != ds) ? dm - r : r; end
      if (m == 0) s = 0;
      rem = (s << w) | m; z = (m == 0); dz = 1'b0;
    end
  endfunction

  // ---- W=4 helpers (all called at #1 after a rising edge) ----
  task automatic send4(input logic [4:0] n, input logic [4:0] d, input bit m, input string tag);
    chk({tag, "_in_ready"}, 32'(b4.in_ready), 32'd1);
    b4.in_valid = 1'b1; b4.numerator = n; b4.denominator = d; b4.mode = m;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (b4.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop4(input int lat, input string tag);
    exp_t e;
    if (q4.size() == 0) begin
      nchk++; nfail++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
      return;
    end
    e = q4.pop_front();
    chk({tag, "_valid"}, 32'(b4.out_valid), 32'd1);
    chk({tag, "_rem"},   32'(b4.remainder), e.rem);
    chk({tag, "_zero"},  32'(b4.zero), 32'(e.z));
    chk({tag, "_dbz"},   32'(b4.divbyzero), 32'(e.dz));
    chk({tag, "_lat"},   32'(lat), 32'(e.lat));
  endtask

  task automatic op4(input logic [4:0] n, input logic [4:0] d, input bit m,
                     input logic [4:0] er, input bit ez, input bit ed, input string tag);
    int lat;
    q4.push_back('{rem: 32'(er), z: ez, dz: ed, lat: ed ? 8'd0 : 8'd4});
    send4(n, d, m, tag);
    wait4(lat);
    pop4(lat, tag);
    @(posedge clk); #1;
    chk({tag, "_hs_ovalid"}, 32'(b4.out_valid), 32'd0);
  endtask

  // ---- W=2 exhaustive operation ----
  task automatic op2(input int n, input int d, input bit m);
    int er, lat; bit ez, ed; exp_t e; string tag;
    tag = $sformatf("w2_n%0d_d%0d_m%0d", n, d, m);
    ref_m(2, n, d, m, er, ez, ed);
    q2.push_back('{rem: 32'(er), z: ez, dz: ed, lat: ed ? 8'd0 : 8'd2});
    b2.in_valid = 1'b1; b2.numerator = 3'(n); b2.denominator = 3'(d); b2.mode = m;
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    lat = 0;
    while (b2.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    e = q2.pop_front();
    chk({tag, "_rem"},  32'(b2.remainder), e.rem);
    chk({tag, "_zero"}, 32'(b2.zero), 32'(e.z));
    chk({tag, "_dbz"},  32'(b2.divbyzero), 32'(e.dz));
    chk({tag, "_lat"},  32'(lat), 32'(e.lat));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [4:0] snap_rem;
    logic       snap_z, snap_dz;
    int lat;

    b4.in_valid = 1'b0; b4.numerator = '0; b4.denominator = '0; b4.mode = 1'b0; b4.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.numerator = '0; b2.denominator = '0; b2.mode = 1'b0; b2.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_ovalid", 32'(b4.out_valid), 32'd0);
    chk("rst_rem",    32'(b4.remainder), 32'd0);
    chk("rst_zero",   32'(b4.zero), 32'd0);
    chk("rst_dbz",    32'(b4.divbyzero), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;

    // First accept right at the first rising edge after release
    op4(5'b0_1101, 5'b0_0100, 1'b0, 5'b0_0001, 1'b0, 1'b0, "pos13_mod4");
    op4(5'b1_1101, 5'b0_0100, 1'b0, 5'b1_0001, 1'b0, 1'b0, "neg13_m0");
    op4(5'b1_1101, 5'b0_0100, 1'b1, 5'b0_0011, 1'b0, 1'b0, "neg13_m1");
    op4(5'b1_1100, 5'b0_0100, 1'b0, 5'b0_0000, 1'b1, 1'b0, "neg12_m0");
    op4(5'b1_1100, 5'b0_0100, 1'b1, 5'b0_0000, 1'b1, 1'b0, "neg12_m1");
    op4(5'b1_0101, 5'b1_0000, 1'b1, 5'b1_0101, 1'b0, 1'b1, "dbz_negzero");
    op4(5'b0_0000, 5'b0_0000, 1'b0, 5'b0_0000, 1'b1, 1'b1, "dbz_zero");
    op4(5'b0_1111, 5'b1_1111, 1'b1, 5'b0_0000, 1'b1, 1'b0, "max_by_max");
    op4(5'b0_0010, 5'b1_0111, 1'b1, 5'b1_0101, 1'b0, 1'b0, "small_floor");

    // Backpressure: result held, inputs ignored while busy
    b4.out_ready = 1'b0;
    q4.push_back('{rem: 32'(5'b1_0001), z: 1'b0, dz: 1'b0, lat: 8'd4});
    send4(5'b0_1011, 5'b1_0011, 1'b1, "stall");
    wait4(lat);
    pop4(lat, "stall");
    snap_rem = b4.remainder; snap_z = b4.zero; snap_dz = b4.divbyzero;
    for (int i = 0; i < 5; i++) begin
      b4.in_valid = 1'b1;
      b4.numerator = 5'($urandom); b4.denominator = 5'($urandom); b4.mode = 1'($urandom);
      @(posedge clk); #1;
      chk("stall_ovalid",  32'(b4.out_valid), 32'd1);
      chk("stall_inready", 32'(b4.in_ready), 32'd0);
      chk("stall_rem",     32'(b4.remainder), 32'(snap_rem));
      chk("stall_zero",    32'(b4.zero), 32'(snap_z));
      chk("stall_dbz",     32'(b4.divbyzero), 32'(snap_dz));
    end
    b4.numerator = 5'b0_1110; b4.denominator = 5'b0_0100; b4.mode = 1'b0;
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("turn_ovalid",  32'(b4.out_valid), 32'd0);
    chk("turn_inready", 32'(b4.in_ready), 32'd1);
    q4.push_back('{rem: 32'(5'b0_0010), z: 1'b0, dz: 1'b0, lat: 8'd4});
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    chk("turn_accepted", 32'(b4.in_ready), 32'd0);
    wait4(lat);
    pop4(lat, "turn");
    @(posedge clk); #1;

    // Reset during the second CALC cycle aborts the operation
    send4(5'b0_1111, 5'b0_0010, 1'b0, "abort");
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("abort_ovalid",  32'(b4.out_valid), 32'd0);
    chk("abort_rem",     32'(b4.remainder), 32'd0);
    chk("abort_zero",    32'(b4.zero), 32'd0);
    chk("abort_dbz",     32'(b4.divbyzero), 32'd0);
    chk("abort_inready", 32'(b4.in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(b4.out_valid), 32'd0);
    end
    op4(5'b0_0111, 5'b0_0011, 1'b0, 5'b0_0001, 1'b0, 1'b0, "post_abort");

    // W=2 exhaustive against the model
    for (int n = 0; n < 8; n++)
      for (int d = 0; d < 8; d++)
        for (int m = 0; m < 2; m++)
          op2(n, d, 1'(m));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/seq_rem.md
SEQ_REM -- requirements
Module: seq_rem

Interface
REQ-001 Parameter W, default 2, magnitude width of each operand; legal range 2..16.
REQ-002 Operand and remainder format SHALL be sign-magnitude, W+1 bits: bit W is the sign (1 = negative), bits W-1:0 are the magnitude.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 in_valid  in  1  operands and mode presented.
REQ-006 in_ready  out  1  block can accept operands.
REQ-007 numerator  in  W+1  dividend, sign-magnitude.
REQ-008 denominator  in  W+1  divisor, sign-magnitude.
REQ-009 mode  in  1  0 = truncated remainder (sign follows numerator); 1 = floored remainder (sign follows denominator).
REQ-010 out_valid  out  1  result registers hold a completed result.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 remainder  out  W+1  result, sign-magnitude.
REQ-013 zero  out  1  remainder magnitude is 0.
REQ-014 divbyzero  out  1  denominator magnitude was 0 (either sign).

Function
REQ-015 FSM states SHALL be IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 Accept: in_valid && in_ready at a rising edge latches numerator, denominator and mode; input values at other times are ignored.
REQ-017 Accept with denominator magnitude 0: IDLE -> DONE; out_valid visible in the cycle after accept; divbyzero = 1; remainder = latched numerator (sign and magnitude); zero = (numerator magnitude == 0); mode ignored.
REQ-018 Accept with nonzero denominator magnitude: IDLE -> CALC; W restoring shift-subtract iterations, one per cycle, under a down-counter loaded with W-1.
REQ-019 Latency: if accept is at edge T, out_valid SHALL be visible in cycle T+W+1 (W CALC cycles, then DONE).
REQ-020 Magnitude result r = |numerator| mod |denominator|, computed on W-bit magnitudes; no intermediate overflow (partial remainder register is W+1 bits).
REQ-021 Mode 0: sign = numerator sign; magnitude = r.
REQ-022 Mode 1: if r != 0 and operand signs differ, magnitude = |denominator| - r; otherwise magnitude = r; sign = denominator sign.
REQ-023 When the final magnitude is 0, sign SHALL be forced to 0 (no -0) and zero = 1; divbyzero = 0 in every non-divide-by-zero result.
REQ-024 DONE: remainder, zero, divbyzero SHALL stay stable while out_ready = 0; on out_valid && out_ready, DONE -> IDLE.
REQ-025 No same-cycle turnaround: in_ready rises in the cycle after the result handshake; in_valid during CALC/DONE is not accepted and not stored.
REQ-026 Result outputs update only on the transition into DONE; they retain the last result while in IDLE and CALC.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter 0, in_ready = 1 after release, out_valid = 0, remainder = 0, zero = 0, divbyzero = 0.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation; no out_valid for the aborted operation after release.
REQ-029 First accept is possible at the first rising edge with rst_n high.

Verification
REQ-030 W=4, mode 0, numerator 0_1101 (+13), denominator 0_0100 (+4), out_ready=1 -> out_valid in cycle T+5, remainder 0_0001, zero 0, divbyzero 0.
REQ-031 W=4, numerator 1_1101 (-13), denominator 0_0100: mode 0 -> remainder 1_0001; mode 1 -> remainder 0_0011; numerator 1_1100 (-12), either mode -> remainder 0_0000, zero 1.
REQ-032 W=4, numerator 1_0101, denominator 1_0000 (-0) -> out_valid in cycle T+1, divbyzero 1, remainder 1_0101, zero 0; numerator 0_0000, denominator 0_0000 -> remainder 0_0000, zero 1, divbyzero 1.
REQ-033 W=4, out_ready held 0 for 5 cycles after out_valid, in_valid held 1 with changing operands -> outputs unchanged, in_ready 0 throughout, exactly one result delivered, next accept no earlier than the cycle after the handshake.
REQ-034 W=4, rst_n pulsed low during the second CALC cycle -> all outputs 0 immediately, out_valid never asserted for that operation; next operation 0_0111 mod 0_0011 mode 0 -> 0_0001.
REQ-035 W=2 exhaustive: all 8 numerators x 8 denominators x 2 modes against a reference model of REQ-017..REQ-023, each with latency per REQ-017/REQ-019.
